// File: rtl/max_pool_ctrl_pkg.sv
// rtl/max_pool_ctrl_pkg.sv - shared pooling types and default widths
package max_pool_ctrl_pkg;

  localparam int DEFAULT_FEATURE_WIDTH = 32;
  localparam int DEFAULT_LEN_WIDTH     = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/max_pool_ctrl_if.sv
// rtl/max_pool_ctrl_if.sv - feature-in / max-out stream bundle for the pooling controller
interface max_pool_ctrl_if
  import max_pool_ctrl_pkg::*;
#(
  parameter int FEATURE_WIDTH = DEFAULT_FEATURE_WIDTH,
  parameter int LEN_WIDTH     = DEFAULT_LEN_WIDTH
) ();

  logic [LEN_WIDTH-1:0]            cfg_len;
  logic                            in_valid;
  logic                            in_ready;
  logic signed [FEATURE_WIDTH-1:0] in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic signed [FEATURE_WIDTH-1:0] out_data;
  logic                            busy;

  // Upstream buffer / downstream write-back side.
  modport master (
    output cfg_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // Pooling controller side.
  modport slave (
    input  cfg_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/max_pool_ctrl_comparator.sv
// rtl/max_pool_ctrl_comparator.sv - registered signed max of two operands
module comparator_unit
  import max_pool_ctrl_pkg::*;
#(
  parameter int FEATURE_WIDTH = DEFAULT_FEATURE_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [FEATURE_WIDTH-1:0] a,
  input  logic signed [FEATURE_WIDTH-1:0] b,
  output logic signed [FEATURE_WIDTH-1:0] max_out
);

  logic signed [FEATURE_WIDTH-1:0] max_q;

  // Register the larger operand; a wins ties, which is invisible at the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
    end else begin
      max_q <= (a >= b) ? a : b;
    end
  end

  assign max_out = max_q;

endmodule

// File: rtl/max_pool_ctrl.sv
// rtl/max_pool_ctrl.sv - streaming window max-pooling controller
module max_pool_ctrl
  import max_pool_ctrl_pkg::*;
#(
  parameter int FEATURE_WIDTH = DEFAULT_FEATURE_WIDTH,
  parameter int LEN_WIDTH     = DEFAULT_LEN_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  max_pool_ctrl_if.slave bus
);

  state_t                          state;
  state_t                          state_nxt;
  logic [LEN_WIDTH-1:0]            cnt;
  logic [LEN_WIDTH-1:0]            len_q;
  logic [LEN_WIDTH-1:0]            cfg_eff;
  logic [LEN_WIDTH-1:0]            eff_len;
  logic                            in_ready_int;
  logic                            out_valid_int;
  logic                            acc;
  logic                            first;
  logic                            last;
  logic signed [FEATURE_WIDTH-1:0] op_a;
  logic signed [FEATURE_WIDTH-1:0] op_b;
  logic signed [FEATURE_WIDTH-1:0] cmp_out;

  // A zero length would never close a window, so it behaves as length 1.
  assign cfg_eff = (bus.cfg_len == '0) ? LEN_WIDTH'(1) : bus.cfg_len;

  // Acceptance depends only on state, keeping the handshake free of comb loops.
  assign acc     = bus.in_valid & (state == ACCUM);
  assign first   = acc & (cnt == '0);
  assign eff_len = first ? cfg_eff : len_q;
  assign last    = acc & (cnt == (eff_len - LEN_WIDTH'(1)));

  // Non-accept cycles feed the held maximum to both inputs; the first word seeds both.
  assign op_a = acc   ? bus.in_data : cmp_out;
  assign op_b = first ? bus.in_data : cmp_out;

  comparator_unit #(
    .FEATURE_WIDTH (FEATURE_WIDTH)
  ) u_cmp (
    .clk     (clk),
    .rst_n   (~rst),
    .a       (op_a),
    .b       (op_b),
    .max_out (cmp_out)
  );

  // State register; reset aborts any window and drops out_valid immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs; DONE refuses input even while draining.
  always_comb begin
    state_nxt     = state;
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    case (state)
      ACCUM: begin
        in_ready_int = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_int = 1'b1;
        if (bus.out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  // Word counter and latched window length; cfg_len is only looked at on the first word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      len_q <= LEN_WIDTH'(1);
    end else if (acc) begin
      if (first) begin
        len_q <= cfg_eff;
      end
      if (last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + LEN_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = cmp_out;
  assign bus.busy      = (cnt != '0) | (state == DONE);

endmodule

// File: tb/tb_max_pool_ctrl.sv
// tb/tb_max_pool_ctrl.sv - directed self-checking bench for max_pool_ctrl
module tb_max_pool_ctrl;
  import max_pool_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  max_pool_ctrl_if bus ();

  max_pool_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one word at a negedge; it is accepted on the following posedge.
  task automatic send(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    check("send_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.cfg_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_out_data",  bus.out_data,       32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready",  32'(bus.in_ready),  32'd1);

    // Basic window of 4
    bus.cfg_len   = 4'd4;
    bus.out_ready = 1'b1;
    send(32'd3);
    send(-32'sd7);
    send(32'd12);
    check("t1_busy_mid",   32'(bus.busy),      32'd1);
    check("t1_early_vld",  32'(bus.out_valid), 32'd0);
    send(32'd5);
    check("t1_out_valid",  32'(bus.out_valid), 32'd1);
    check("t1_out_data",   bus.out_data,       32'd12);
    check("t1_in_ready",   32'(bus.in_ready),  32'd0);
    @(negedge clk);
    check("t1_back_vld",   32'(bus.out_valid), 32'd0);
    check("t1_back_rdy",   32'(bus.in_ready),  32'd1);
    check("t1_back_busy",  32'(bus.busy),      32'd0);

    // Negative and extreme values
    bus.cfg_len = 4'd3;
    send(-32'sd9);
    send(-32'sd2);
    send(32'h8000_0000);
    check("t2a_out_valid", 32'(bus.out_valid), 32'd1);
    check("t2a_out_data",  bus.out_data,       32'hFFFF_FFFE);
    @(negedge clk);
    send(32'h7FFF_FFFF);
    send(32'd0);
    send(32'hFFFF_FFFF);
    check("t2b_out_valid", 32'(bus.out_valid), 32'd1);
    check("t2b_out_data",  bus.out_data,       32'h7FFF_FFFF);
    @(negedge clk);

    // Backpressure, with a word offered while DONE that must not be taken
    bus.cfg_len   = 4'd2;
    bus.out_ready = 1'b0;
    send(32'd1);
    send(32'd8);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd1000;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t3_hold_data",  bus.out_data,       32'd8);
      check("t3_hold_rdy",   32'(bus.in_ready),  32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t3_bubble_vld",  32'(bus.out_valid), 32'd0);
    check("t3_bubble_busy", 32'(bus.busy),      32'd0);
    send(32'd4);
    send(32'd6);
    check("t3b_out_valid", 32'(bus.out_valid), 32'd1);
    check("t3b_out_data",  bus.out_data,       32'd6);
    @(negedge clk);

    // Input gaps and mid-window config change
    bus.cfg_len = 4'd3;
    send(32'd5);
    bus.cfg_len = 4'd1;
    repeat (2) @(negedge clk);
    check("t4_gap_busy",   32'(bus.busy),      32'd1);
    check("t4_gap_vld",    32'(bus.out_valid), 32'd0);
    send(32'd10);
    check("t4_two_vld",    32'(bus.out_valid), 32'd0);
    @(negedge clk);
    send(32'd2);
    check("t4_out_valid",  32'(bus.out_valid), 32'd1);
    check("t4_out_data",   bus.out_data,       32'd10);
    @(negedge clk);
    send(32'd77);
    check("t4b_out_valid", 32'(bus.out_valid), 32'd1);
    check("t4b_out_data",  bus.out_data,       32'd77);
    @(negedge clk);

    // Degenerate lengths 0 and 1
    bus.cfg_len = 4'd0;
    send(32'd42);
    check("t5a_out_valid", 32'(bus.out_valid), 32'd1);
    check("t5a_out_data",  bus.out_data,       32'd42);
    @(negedge clk);
    bus.cfg_len = 4'd1;
    send(-32'sd3);
    check("t5b_out_valid", 32'(bus.out_valid), 32'd1);
    check("t5b_out_data",  bus.out_data,       32'hFFFF_FFFD);
    @(negedge clk);

    // Reset mid-window
    bus.cfg_len = 4'd4;
    send(32'd100);
    send(32'd200);
    check("t6_pre_busy",   32'(bus.busy),      32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_vld",    32'(bus.out_valid), 32'd0);
    check("t6_rst_busy",   32'(bus.busy),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    send(32'd1);
    send(32'd2);
    send(32'd3);
    check("t6_three_vld",  32'(bus.out_valid), 32'd0);
    send(32'd4);
    check("t6_out_valid",  32'(bus.out_valid), 32'd1);
    check("t6_out_data",   bus.out_data,       32'd4);

    // Reset while a result is pending
    rst = 1'b1;
    #1;
    check("t7_rst_vld",    32'(bus.out_valid), 32'd0);
    check("t7_rst_busy",   32'(bus.busy),      32'd0);
    check("t7_rst_data",   bus.out_data,       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t7_rel_rdy",    32'(bus.in_ready),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_pool_ctrl.md
Name: max_pool_ctrl

Overview:
- Streaming max-pooling controller. It accepts signed feature words on a valid/ready input, groups each run of `cfg_len` consecutive words into one window, and emits the window maximum on a valid/ready output.
- It sequences one embedded `comparator_unit` instance, which holds the running maximum through registered feedback.
- It sits between the feature-map buffer and the activation/write-back stage of the pooling layer.

Parameters:
- `FEATURE_WIDTH`, default 32: signed feature word width, passed to `comparator_unit`.
- `LEN_WIDTH`, default 4: width of `cfg_len`; the maximum window length is 2^LEN_WIDTH-1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `cfg_len`, in, LEN_WIDTH: window length. It is sampled on the first handshake of each window. A value of 0 is treated as 1.
- `in_valid`, in, 1: input word valid.
- `in_ready`, out, 1: controller can accept an input word.
- `in_data`, in, FEATURE_WIDTH signed: input feature word.
- `out_valid`, out, 1: window maximum is available.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, FEATURE_WIDTH signed: window maximum.
- `busy`, out, 1: a window is partially accumulated or a result is pending.

Behaviour:
- Clocking and reset: one clock `clk`. Reset `rst` is asynchronous and active-high. The embedded `comparator_unit` gets `rst_n = ~rst`.
- Reset values: state=ACCUM, cnt=0, len_q=1, out_valid=0, busy=0, out_data=0 (comparator output resets to 0). in_ready=1 once rst deasserts.
- FSM has two states:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Input handshake: acc = in_valid & in_ready. first = acc & (cnt==0). eff_len = first ? max(cfg_len,1) : len_q.
- Comparator operand muxing:
  - Input a = acc ? in_data : cmp_out.
  - Input b = first ? in_data : cmp_out.
  - On a non-accept cycle both operands equal cmp_out, so the registered maximum holds.
  - On the first word both operands equal in_data, so the maximum initialises to that word.
- Comparison: signed, a>=b selects a. Ties are invisible at the output.
- ACCUM, on acc:
  - If first, len_q <= max(cfg_len,1).
  - If cnt == eff_len-1: cnt <= 0 and the next state is DONE.
  - Otherwise cnt <= cnt+1.
- ACCUM with no acc: no state change. cfg_len changes mid-window are ignored.
- DONE:
  - out_data = cmp_out, held stable while out_valid=1.
  - On out_ready the next state is ACCUM.
  - No input is accepted in DONE, including the cycle out_ready is high. This gives a one-cycle bubble per window.
- Latency: out_valid rises on the cycle after the last input handshake. Minimum period is len+1 cycles per window.
- Window length 1: every accepted word goes straight to DONE, and out_data equals that word.
- Extreme values: the most negative value (0x80000000 at 32 bits) and the most positive value (0x7FFFFFFF) must be handled correctly by the signed comparison, with no overflow.
- busy = (cnt != 0) | (state == DONE).
- Reset mid-window or in DONE: immediate abort. Partial data is discarded, out_valid drops asynchronously, and accumulation restarts cleanly after release.
- Output stability: out_valid is never deasserted without an out_ready handshake, except by reset.

Decomposition:
- Shared pooling package holds the FSM state enum (ACCUM, DONE) and the default FEATURE_WIDTH and LEN_WIDTH constants.
- One sub-module: the existing `comparator_unit`, instantiated once with FEATURE_WIDTH passed through. All control stays in `max_pool_ctrl`.

Test Plan:
- Basic window: cfg_len=4, words 3, -7, 12, 5 on consecutive cycles, out_ready=1 → out_valid one cycle after the 4th handshake, out_data=12, in_ready=0 that cycle, then ACCUM.
- All-negative window: cfg_len=3, words -9, -2, -0x80000000 → out_data=-2. A second window 0x7FFFFFFF, 0, -1 → 0x7FFFFFFF.
- Backpressure: cfg_len=2, words 1, 8, out_ready held 0 for 5 cycles → out_valid=1 with out_data=8 stable throughout and in_ready=0. Next window 4, 6 → 6.
- Input gaps and config change: cfg_len=3, with in_valid bubbles between 5, 10, 2, and cfg_len changed to 1 after the first word → window still closes after 3 words, out_data=10. The next window uses len 1.
- Degenerate length: cfg_len=0 and cfg_len=1, words 42 then -3 → two results, 42 and -3, each one cycle after its handshake.
- Reset mid-window: cfg_len=4, accept 100, 200, assert rst for one cycle → out_valid=0, busy=0. Then 1, 2, 3, 4 → out_data=4; the pre-reset values 100 and 200 do not appear.
